// File: rtl/module_trap_ctrl_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
package trap_pkg;

  // Sequencer states; all four encodings are used.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ENTER    = 2'd1,
    REDIRECT = 2'd2,
    RETURN   = 2'd3
  } trap_state_e;

  // Synchronous exception codes written to mcause.
  localparam logic [31:0] CAUSE_MISALIGNED = 32'd0;
  localparam logic [31:0] CAUSE_ILLEGAL    = 32'd2;
  localparam logic [31:0] CAUSE_EBREAK     = 32'd3;
  localparam logic [31:0] CAUSE_ECALL      = 32'd11;

  // mcause interrupt flag position.
  localparam int INT_BIT = 31;

  // mtvec MODE field value selecting vectored interrupts.
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

  // Decoded event at commit.
  typedef struct packed {
    logic        event_valid;
    logic        is_irq;
    logic        is_mret;
    logic [31:0] cause;
  } trap_evt_t;

  // Clears the two low bits of an address (mtvec base / mepc target).
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/module_trap_ctrl_prio.sv
// Combinational priority encoder for commit-stage trap and mret events.
module module_trap_prio
  import trap_pkg::*;
#(
  parameter int unsigned IRQ_CAUSE = 11
) (
  input  logic        instr_valid_i,
  input  logic        exc_misaligned_i,
  input  logic        exc_illegal_i,
  input  logic        exc_ebreak_i,
  input  logic        exc_ecall_i,
  input  logic        mret_i,
  input  logic        irq_i,
  input  logic        mie_i,
  output logic        event_valid_o,
  output logic        is_irq_o,
  output logic        is_mret_o,
  output logic [31:0] cause_o
);

  localparam logic [30:0] IRQ_CODE = 31'(IRQ_CAUSE);

  trap_evt_t evt;

  // Highest-priority event wins; nothing is evaluated without a committing instruction.
  always_comb begin
    evt = '0;
    if (instr_valid_i) begin
      if (exc_misaligned_i) begin
        evt.event_valid = 1'b1;
        evt.cause       = CAUSE_MISALIGNED;
      end else if (exc_illegal_i) begin
        evt.event_valid = 1'b1;
        evt.cause       = CAUSE_ILLEGAL;
      end else if (exc_ebreak_i) begin
        evt.event_valid = 1'b1;
        evt.cause       = CAUSE_EBREAK;
      end else if (exc_ecall_i) begin
        evt.event_valid = 1'b1;
        evt.cause       = CAUSE_ECALL;
      end else if (irq_i && mie_i) begin
        evt.event_valid = 1'b1;
        evt.is_irq      = 1'b1;
        evt.cause       = {1'b1, IRQ_CODE};
      end else if (mret_i) begin
        evt.event_valid = 1'b1;
        evt.is_mret     = 1'b1;
      end
    end
  end

  assign event_valid_o = evt.event_valid;
  assign is_irq_o      = evt.is_irq;
  assign is_mret_o     = evt.is_mret;
  assign cause_o       = evt.cause;

endmodule

// File: rtl/module_trap_ctrl.sv
// Machine-mode trap sequencer: trap entry (mepc/mcause write, mtvec redirect)
// and mret return, owning mstatus.MIE/MPIE and pipeline stall/flush.
module module_trap_ctrl
  import trap_pkg::*;
#(
  parameter bit          VECTORED_EN = 1'b1,
  parameter int unsigned IRQ_CAUSE   = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [31:0] instr_pc,
  input  logic        exc_misaligned,
  input  logic        exc_illegal,
  input  logic        exc_ebreak,
  input  logic        exc_ecall,
  input  logic        mret,
  input  logic        irq,
  input  logic        mie_we,
  input  logic        mie_din,
  input  logic [31:0] mtvec_dout,
  input  logic [31:0] mepc_dout,
  output logic        mepc_we,
  output logic [31:0] mepc_din,
  output logic        mcause_we,
  output logic [31:0] mcause_din,
  output logic        stall,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        mie_dout,
  output logic        mpie_dout
);

  trap_state_e state_q, state_d;

  logic [31:0] epc_q, epc_d;
  logic [31:0] cause_q, cause_d;
  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;

  logic        evt_valid;
  logic        evt_irq;
  logic        evt_mret;
  logic [31:0] evt_cause;
  logic        accept;

  logic [31:0] mtvec_base;
  logic        vec_sel;
  logic [31:0] trap_target;

  // mepc is always word aligned on return; its low bits are deliberately ignored.
  logic        unused_mepc_lsb;
  assign unused_mepc_lsb = ^mepc_dout[1:0];

  module_trap_prio #(
    .IRQ_CAUSE(IRQ_CAUSE)
  ) u_prio (
    .instr_valid_i   (instr_valid),
    .exc_misaligned_i(exc_misaligned),
    .exc_illegal_i   (exc_illegal),
    .exc_ebreak_i    (exc_ebreak),
    .exc_ecall_i     (exc_ecall),
    .mret_i          (mret),
    .irq_i           (irq),
    .mie_i           (mie_q),
    .event_valid_o   (evt_valid),
    .is_irq_o        (evt_irq),
    .is_mret_o       (evt_mret),
    .cause_o         (evt_cause)
  );

  // Only IDLE accepts events; irq arriving in any other state is simply not seen.
  assign accept = (state_q == IDLE) && evt_valid;

  // Interrupts may be vectored; exceptions always land on the base address.
  assign mtvec_base  = align_word(mtvec_dout);
  assign vec_sel     = VECTORED_EN && (mtvec_dout[1:0] == MTVEC_MODE_VECTORED) && cause_q[INT_BIT];
  assign trap_target = vec_sel ? (mtvec_base + {cause_q[29:0], 2'b00}) : mtvec_base;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; any unexpected encoding falls back to IDLE.
  always_comb begin
    state_d = IDLE;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = evt_mret ? RETURN : ENTER;
        end else begin
          state_d = IDLE;
        end
      end
      ENTER:    state_d = REDIRECT;
      REDIRECT: state_d = IDLE;
      RETURN:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Output decode; everything is held at zero while reset is asserted.
  always_comb begin
    mepc_we        = 1'b0;
    mepc_din       = '0;
    mcause_we      = 1'b0;
    mcause_din     = '0;
    stall          = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if (reset) begin
      unique case (state_q)
        IDLE: begin
          stall = accept;
          flush = accept;
        end
        ENTER: begin
          mepc_we    = 1'b1;
          mepc_din   = epc_q;
          mcause_we  = 1'b1;
          mcause_din = cause_q;
          stall      = 1'b1;
        end
        REDIRECT: begin
          redirect_valid = 1'b1;
          redirect_pc    = trap_target;
          stall          = 1'b1;
          flush          = 1'b1;
        end
        RETURN: begin
          redirect_valid = 1'b1;
          redirect_pc    = align_word(mepc_dout);
          flush          = 1'b1;
        end
        default: begin
          stall = 1'b0;
        end
      endcase
    end
  end

  assign mie_dout  = mie_q;
  assign mpie_dout = mpie_q;

  // Next values for the trap context and mstatus bits; software MIE writes
  // lose to any accepted event and to an in-flight sequence.
  always_comb begin
    epc_d   = epc_q;
    cause_d = cause_q;
    mie_d   = mie_q;
    mpie_d  = mpie_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (!evt_mret) begin
            epc_d   = instr_pc;
            cause_d = evt_cause;
          end
        end else if (mie_we) begin
          mie_d = mie_din;
        end
      end
      ENTER: begin
        mpie_d = mie_q;
        mie_d  = 1'b0;
      end
      RETURN: begin
        mie_d  = mpie_q;
        mpie_d = 1'b1;
      end
      default: begin
        mie_d = mie_q;
      end
    endcase
  end

  // Trap context and mstatus registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      epc_q   <= '0;
      cause_q <= '0;
      mie_q   <= 1'b0;
      mpie_q  <= 1'b0;
    end else begin
      epc_q   <= epc_d;
      cause_q <= cause_d;
      mie_q   <= mie_d;
      mpie_q  <= mpie_d;
    end
  end

endmodule

// File: tb/tb_module_trap_ctrl.sv
// Scoreboard bench for module_trap_ctrl: the driver predicts each cycle's
// outputs from a transaction-level model of the trap rules, the monitor compares.
module tb_module_trap_ctrl;

  localparam bit          VEC = 1'b1;
  localparam int unsigned IRQ = 11;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic        exc_misaligned, exc_illegal, exc_ebreak, exc_ecall;
  logic        mret, irq, mie_we, mie_din;
  logic [31:0] mtvec_dout, mepc_dout;
  logic        mepc_we, mcause_we, stall, flush, redirect_valid;
  logic [31:0] mepc_din, mcause_din, redirect_pc;
  logic        mie_dout, mpie_dout;

  module_trap_ctrl #(.VECTORED_EN(VEC), .IRQ_CAUSE(IRQ)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_pc(instr_pc),
    .exc_misaligned(exc_misaligned), .exc_illegal(exc_illegal),
    .exc_ebreak(exc_ebreak), .exc_ecall(exc_ecall), .mret(mret), .irq(irq),
    .mie_we(mie_we), .mie_din(mie_din), .mtvec_dout(mtvec_dout),
    .mepc_dout(mepc_dout), .mepc_we(mepc_we), .mepc_din(mepc_din),
    .mcause_we(mcause_we), .mcause_din(mcause_din), .stall(stall),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mie_dout(mie_dout), .mpie_dout(mpie_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst_n;
    logic        iv;
    logic [31:0] pc;
    logic        mis, ill, ebr, ecl, mrt, irq, mwe, mdin;
    logic        set_mtvec;
    logic [31:0] mtvec;
    logic        set_mepc;
    logic [31:0] mepc;
  } stim_t;

  typedef struct packed {
    logic        stall, flush, mepc_we;
    logic [31:0] mepc_din;
    logic        mcause_we;
    logic [31:0] mcause_din;
    logic        rv;
    logic [31:0] rpc;
    logic        mie, mpie;
  } exp_t;

  typedef struct {
    exp_t  e;
    string tag;
  } sb_t;

  // A future cycle of an accepted sequence and its effect on mstatus.
  typedef struct {
    exp_t e;
    int   act;   // 0 none, 1 trap entry (MIE->MPIE, MIE=0, mepc written), 2 mret
  } pend_t;

  sb_t   sb_q[$];
  pend_t pend[$];

  int checks   = 0;
  int failures = 0;

  // Reference state: mstatus bits and the CSR file contents the bench plays.
  logic        m_mie, m_mpie;
  logic [31:0] csr_mtvec, csr_mepc;
  string       cur_tag;

  function automatic stim_t idle_stim();
    stim_t s;
    s       = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  // One clock cycle: drive inputs, predict outputs, advance the model.
  task automatic step(input stim_t s);
    exp_t  e;
    pend_t p;
    logic  got, is_irq, is_mret;
    logic [31:0] cause, base, mt;
    e = '0;
    if (pend.size() == 0 && s.set_mtvec) csr_mtvec = s.mtvec;
    if (pend.size() == 0 && s.set_mepc)  csr_mepc  = s.mepc;
    reset = s.rst_n; instr_valid = s.iv; instr_pc = s.pc;
    exc_misaligned = s.mis; exc_illegal = s.ill; exc_ebreak = s.ebr;
    exc_ecall = s.ecl; mret = s.mrt; irq = s.irq; mie_we = s.mwe; mie_din = s.mdin;
    mtvec_dout = csr_mtvec; mepc_dout = csr_mepc;

    if (!s.rst_n) begin
      pend.delete();
      m_mie = 1'b0; m_mpie = 1'b0;
      e = '0;
    end else if (pend.size() > 0) begin
      p = pend.pop_front();
      e = p.e; e.mie = m_mie; e.mpie = m_mpie;
      if (p.act == 1) begin
        m_mpie = m_mie; m_mie = 1'b0; csr_mepc = p.e.mepc_din;
      end else if (p.act == 2) begin
        m_mie = m_mpie; m_mpie = 1'b1;
      end
    end else begin
      got = 1'b0; is_irq = 1'b0; is_mret = 1'b0; cause = 32'd0;
      if (s.iv) begin
        if      (s.mis) begin got = 1'b1; cause = 32'd0;  end
        else if (s.ill) begin got = 1'b1; cause = 32'd2;  end
        else if (s.ebr) begin got = 1'b1; cause = 32'd3;  end
        else if (s.ecl) begin got = 1'b1; cause = 32'd11; end
        else if (s.irq && m_mie) begin got = 1'b1; is_irq = 1'b1; cause = 32'h8000_0000 | IRQ; end
        else if (s.mrt) begin got = 1'b1; is_mret = 1'b1; end
      end
      e.mie = m_mie; e.mpie = m_mpie;
      if (got) begin
        e.stall = 1'b1; e.flush = 1'b1;
        if (is_mret) begin
          p.e = '0; p.act = 2;
          p.e.rv = 1'b1; p.e.flush = 1'b1; p.e.rpc = csr_mepc & 32'hFFFF_FFFC;
          pend.push_back(p);
        end else begin
          p.e = '0; p.act = 1;
          p.e.stall = 1'b1; p.e.mepc_we = 1'b1; p.e.mepc_din = s.pc;
          p.e.mcause_we = 1'b1; p.e.mcause_din = cause;
          pend.push_back(p);
          mt   = csr_mtvec;
          base = mt & 32'hFFFF_FFFC;
          if (VEC && mt[1:0] == 2'b01 && is_irq) base = base + 4 * (cause & 32'h7FFF_FFFF);
          p.e = '0; p.act = 0;
          p.e.rv = 1'b1; p.e.stall = 1'b1; p.e.flush = 1'b1; p.e.rpc = base;
          pend.push_back(p);
        end
      end else if (s.mwe) begin
        m_mie = s.mdin;
      end
    end
    sb_q.push_back('{e: e, tag: cur_tag});
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every presented cycle against the oldest prediction.
  initial begin
    sb_t  sb;
    exp_t act;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        sb  = sb_q.pop_front();
        act = {stall, flush, mepc_we, mepc_din, mcause_we, mcause_din,
               redirect_valid, redirect_pc, mie_dout, mpie_dout};
        checks++;
        if (act !== sb.e) begin
          failures++;
          $display("FAIL %s got st=%b fl=%b mw=%b md=%h cw=%b cd=%h rv=%b rp=%h mie=%b mpie=%b | exp st=%b fl=%b mw=%b md=%h cw=%b cd=%h rv=%b rp=%h mie=%b mpie=%b",
                   sb.tag, act.stall, act.flush, act.mepc_we, act.mepc_din, act.mcause_we,
                   act.mcause_din, act.rv, act.rpc, act.mie, act.mpie,
                   sb.e.stall, sb.e.flush, sb.e.mepc_we, sb.e.mepc_din, sb.e.mcause_we,
                   sb.e.mcause_din, sb.e.rv, sb.e.rpc, sb.e.mie, sb.e.mpie);
        end
      end
    end
  end

  initial begin
    stim_t s;
    m_mie = 1'b0; m_mpie = 1'b0; csr_mtvec = 32'h0; csr_mepc = 32'h0;
    reset = 1'b0; instr_valid = 1'b0; instr_pc = '0;
    exc_misaligned = 1'b0; exc_illegal = 1'b0; exc_ebreak = 1'b0; exc_ecall = 1'b0;
    mret = 1'b0; irq = 1'b0; mie_we = 1'b0; mie_din = 1'b0;
    mtvec_dout = '0; mepc_dout = '0;
    @(posedge clk); #1;

    // Reset holds every output low even with live events on the inputs.
    cur_tag = "reset";
    s = idle_stim(); s.rst_n = 1'b0; s.iv = 1'b1; s.irq = 1'b1; s.ecl = 1'b1; s.pc = 32'h40;
    repeat (2) step(s);
    cur_tag = "post_reset";
    repeat (2) step(idle_stim());

    // ECALL trap entry to a direct-mode mtvec.
    cur_tag = "ecall";
    s = idle_stim(); s.iv = 1'b1; s.ecl = 1'b1; s.pc = 32'h100; s.set_mtvec = 1'b1; s.mtvec = 32'h200;
    step(s);
    repeat (3) step(idle_stim());

    // Illegal beats ecall and a pending enabled irq; irq masked afterwards.
    cur_tag = "prio";
    s = idle_stim(); s.mwe = 1'b1; s.mdin = 1'b1;
    step(s);
    s = idle_stim(); s.iv = 1'b1; s.ill = 1'b1; s.ecl = 1'b1; s.irq = 1'b1; s.pc = 32'h140;
    step(s);
    s = idle_stim(); s.iv = 1'b1; s.irq = 1'b1; s.pc = 32'h144;
    repeat (4) step(s);

    // Vectored external interrupt.
    cur_tag = "vec_irq";
    s = idle_stim(); s.mwe = 1'b1; s.mdin = 1'b1; s.set_mtvec = 1'b1; s.mtvec = 32'h301;
    step(s);
    s = idle_stim(); s.iv = 1'b1; s.irq = 1'b1; s.pc = 32'h80;
    step(s);
    repeat (3) step(idle_stim());

    // mret back to mepc, then mret losing to ebreak.
    cur_tag = "mret";
    s = idle_stim(); s.set_mepc = 1'b1; s.mepc = 32'h84; s.mwe = 1'b1; s.mdin = 1'b1;
    step(s);
    s = idle_stim(); s.iv = 1'b1; s.mrt = 1'b1; s.pc = 32'h90;
    step(s);
    repeat (2) step(idle_stim());
    cur_tag = "mret_ebreak";
    s = idle_stim(); s.iv = 1'b1; s.mrt = 1'b1; s.ebr = 1'b1; s.pc = 32'h94;
    step(s);
    repeat (3) step(idle_stim());

    // Reset during ENTER abandons the sequence.
    cur_tag = "mid_reset";
    s = idle_stim(); s.iv = 1'b1; s.ecl = 1'b1; s.pc = 32'h120;
    step(s);
    s = idle_stim(); s.rst_n = 1'b0;
    step(s);
    repeat (3) step(idle_stim());

    // Randomised traffic.
    cur_tag = "random";
    for (int i = 0; i < 600; i++) begin
      s = idle_stim();
      s.rst_n     = ($urandom_range(0, 99) != 0);
      s.iv        = ($urandom_range(0, 9) < 7);
      s.pc        = $urandom;
      s.mis       = ($urandom_range(0, 19) == 0);
      s.ill       = ($urandom_range(0, 14) == 0);
      s.ebr       = ($urandom_range(0, 14) == 0);
      s.ecl       = ($urandom_range(0, 9) == 0);
      s.mrt       = ($urandom_range(0, 7) == 0);
      s.irq       = ($urandom_range(0, 2) == 0);
      s.mwe       = ($urandom_range(0, 5) == 0);
      s.mdin      = ($urandom_range(0, 3) != 0);
      s.set_mtvec = ($urandom_range(0, 9) == 0);
      s.mtvec     = $urandom;
      s.set_mepc  = ($urandom_range(0, 9) == 0);
      s.mepc      = $urandom;
      step(s);
    end

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending predictions, want 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/module_trap_ctrl.md
Name: module_trap_ctrl

Overview:
- Machine-mode trap sequencer sitting beside module_csr in the core's writeback/commit stage.
- Prioritises synchronous exceptions and the external interrupt, then sequences trap entry into module_csr: writes mepc/mcause via the dedicated ports, then redirects the PC to mtvec.
- Sequences mret by redirecting to mepc.
- Owns mstatus.MIE/MPIE and stalls/flushes the pipeline while a sequence is in flight.

Parameters:
- VECTORED_EN, 1, 1 enables mtvec vectored mode for interrupts (mtvec[1:0]==2'b01); 0 forces direct mode always.
- IRQ_CAUSE, 11, interrupt code placed in mcause[30:0] for the external interrupt.

Ports:
- clk  input  1  core clock.
- reset  input  1  reset; asynchronous, active-low (0 = in reset).
- instr_valid  input  1  instruction at instr_pc is at commit this cycle.
- instr_pc  input  32  PC of the committing instruction.
- exc_misaligned  input  1  fetch address misaligned; qualified by instr_valid.
- exc_illegal  input  1  illegal instruction; qualified by instr_valid.
- exc_ebreak  input  1  EBREAK; qualified by instr_valid.
- exc_ecall  input  1  ECALL; qualified by instr_valid.
- mret  input  1  MRET at commit; qualified by instr_valid.
- irq  input  1  external interrupt, level-sensitive, already synchronised.
- mie_we  input  1  software write of mstatus.MIE.
- mie_din  input  1  value for mstatus.MIE.
- mtvec_dout  input  32  from module_csr.
- mepc_dout  input  32  from module_csr.
- mepc_we  output  1  to module_csr.
- mepc_din  output  32  to module_csr.
- mcause_we  output  1  to module_csr.
- mcause_din  output  32  to module_csr.
- stall  output  1  hold the pipeline; the committing instruction must not retire.
- flush  output  1  squash all younger instructions.
- redirect_valid  output  1  load redirect_pc into the PC this cycle.
- redirect_pc  output  32  new PC.
- mie_dout  output  1  current mstatus.MIE.
- mpie_dout  output  1  current mstatus.MPIE.

Behaviour:
- Reset values:
  - State IDLE.
  - Outputs: all 0.
  - Internal: mie=0, mpie=0, cause_q=0, epc_q=0.
- Event priority at IDLE when instr_valid=1:
  - misaligned (cause 0) > illegal (2) > ebreak (3) > ecall (11) > irq (only if irq & mie; cause {1'b1, IRQ_CAUSE}) > mret.
  - mret with any exception: the exception wins.
- Trap event, cycle N (IDLE):
  - stall=1 and flush=1, combinational in the same cycle; the instruction does not retire.
  - Latch epc_q<=instr_pc and cause_q<=cause. Next state: ENTER.
  - For an interrupt, instr_pc is preempted, so mepc = instr_pc.
- ENTER, cycle N+1:
  - mepc_we=1, mepc_din=epc_q; mcause_we=1, mcause_din=cause_q.
  - mpie<=mie, mie<=0. stall=1.
  - Next state: REDIRECT.
- REDIRECT, cycle N+2:
  - redirect_valid=1, stall=1, flush=1.
  - redirect_pc={mtvec[31:2], 2'b00}.
  - Exception: vectored only if VECTORED_EN, mtvec[1:0]==01 and cause_q[31]; then redirect_pc = base + 4*cause_q[30:0], 32-bit wrap-around.
  - Next state: IDLE. Pipeline resumes at N+3.
- mret event, cycle N (IDLE):
  - stall=1, flush=1. Next state: RETURN.
- RETURN, cycle N+1:
  - redirect_valid=1, redirect_pc={mepc_dout[31:2], 2'b00}.
  - mie<=mpie, mpie<=1. flush=1.
  - Next state: IDLE.
- irq outside IDLE: ignored, not latched. irq is level, so it is re-evaluated in IDLE against the updated mie.
- mie_we:
  - Honoured only in IDLE with no event accepted that cycle.
  - If mie_we coincides with an accepted event, or arrives in ENTER/REDIRECT/RETURN, the write is dropped; trap sequencing owns mie.
- instr_valid=0 in IDLE: no event is evaluated; stall=0 and flush=0.
- Reset asserted mid-sequence:
  - Immediate return to IDLE with all outputs 0, regardless of state.
  - Partial CSR writes are not replayed.
- Illegal state encoding: recover to IDLE.

Decomposition:
- Package trap_pkg:
  - State enum (IDLE, ENTER, REDIRECT, RETURN).
  - Cause constants: CAUSE_MISALIGNED=0, CAUSE_ILLEGAL=2, CAUSE_EBREAK=3, CAUSE_ECALL=11, INT_BIT=31.
- Sub-module module_trap_prio: combinational priority encoder producing event_valid, is_irq, is_mret and the 32-bit cause.

Test Plan:
- Reset: reset=0 with irq=1, exc_ecall=1 -> every output 0, mie_dout=0; release reset, instr_valid=0 -> outputs stay 0.
- ECALL: instr_pc=0x100, mtvec=0x200 -> N: stall=1, flush=1; N+1: mepc_we=1, mepc_din=0x100, mcause_din=11, mie_dout=0 afterwards; N+2: redirect_valid=1, redirect_pc=0x200; N+3: stall=0.
- Priority: exc_illegal and exc_ecall together, irq=1, mie=1 -> mcause_din=2; irq is then blocked because mie=0 after entry.
- Vectored interrupt: mie_we=1, mie_din=1, then irq=1 with instr_pc=0x80 and mtvec=0x301 -> mepc_din=0x80, mcause_din=0x8000000B, redirect_pc=0x32C, mpie_dout=1.
- mret: mepc=0x84 -> N+1: redirect_pc=0x84, mie_dout=1, mpie_dout=1; mret together with exc_ebreak -> mcause_din=3, no RETURN state.
- Mid-sequence reset: reset=0 during ENTER -> mepc_we=0 immediately; after release the state is IDLE and redirect_valid stays 0.
